// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, instruction
// width, PC step and the fetch FSM state encodings.
package instr_fetch_pkg;

    localparam logic [31:0] IF_RESETPC = 32'h0000_0000;
    localparam int          IF_INSTR_W = 32;
    localparam int          IF_PC_INC  = 4;

    // state  | meaning
    // F_BOOT | one idle cycle after reset, no request
    // F_REQ  | request outstanding at pc, waiting for a hit
    // F_FULL | buffer full, request withdrawn until decode pops
    typedef enum logic [1:0] {
        F_BOOT = 2'd0,
        F_REQ  = 2'd1,
        F_FULL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Fetched-instruction buffer: DEPTH entries of {pc, instr}, power-of-two depth,
// flush has priority over push/pop. Head outputs read 0 while empty.
module instr_fetch_fifo #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int PTRW = $clog2(DEPTH),
    localparam int CNTW = PTRW + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push_i,
    input  logic [AW-1:0]   push_pc_i,
    input  logic [DW-1:0]   push_instr_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [CNTW-1:0] count_o,
    output logic [AW-1:0]   head_pc_o,
    output logic [DW-1:0]   head_instr_o
);

    logic [AW-1:0]   pc_mem_q    [DEPTH];
    logic [DW-1:0]   instr_mem_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q;
    logic [PTRW-1:0] rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            push_ok;
    logic            pop_ok;

    assign full_o   = (count_q == CNTW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign push_ok  = push_i && !full_o && !flush_i;
    assign pop_ok   = pop_i && !empty_o && !flush_i;

    // Registered storage; the head is a plain read of the entry flops.
    assign head_pc_o    = empty_o ? '0 : pc_mem_q[rd_ptr_q];
    assign head_instr_o = empty_o ? '0 : instr_mem_q[rd_ptr_q];

    // Entry storage, written only on a successful push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
            instr_mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks push minus pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNTW'(push_ok) - CNTW'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one cache request at a time at pc, buffers
// returned words with their PC, and restarts at a redirect target on demand.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                  ADDRBITS  = 32,
    parameter int                  DATABITS  = IF_INSTR_W,
    parameter logic [ADDRBITS-1:0] RESETPC   = ADDRBITS'(IF_RESETPC),
    parameter int                  FIFODEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [ADDRBITS-1:0] icache_addr,
    output logic                icache_rdreq,
    input  logic [DATABITS-1:0] icache_out,
    input  logic                icache_out_valid,
    input  logic                icache_ready,
    input  logic                redirect_valid,
    input  logic [ADDRBITS-1:0] redirect_pc,
    output logic [DATABITS-1:0] instr_out,
    output logic [ADDRBITS-1:0] instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready
);

    localparam int CNTW = $clog2(FIFODEPTH) + 1;

    fetch_state_e        state_q;
    logic [ADDRBITS-1:0] pc_q;
    logic                rdreq_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNTW-1:0]     fifo_count;
    logic [CNTW-1:0]     count_d;
    logic                accept;
    logic                pop;

    // A response is taken only for the live request and only with room to store it.
    assign accept = (state_q == F_REQ) && rdreq_q && icache_out_valid &&
                    icache_ready && !redirect_valid && !fifo_full;
    // A redirect cancels any same-cycle pop; the buffer is flushed instead.
    assign pop    = instr_valid && instr_ready && !redirect_valid;

    // Occupancy after this edge, used to decide entry into / exit from F_FULL.
    assign count_d = fifo_count + CNTW'(accept) - CNTW'(pop);

    assign icache_addr  = pc_q;
    assign icache_rdreq = rdreq_q;
    assign instr_valid  = !fifo_empty;

    // Fetch FSM with registered request strobe; redirect overrides every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= F_BOOT;
            pc_q    <= RESETPC;
            rdreq_q <= 1'b0;
        end else if (redirect_valid) begin
            state_q <= F_REQ;
            pc_q    <= redirect_pc & ~ADDRBITS'(3);
            rdreq_q <= 1'b1;
        end else begin
            case (state_q)
                F_BOOT: begin
                    state_q <= F_REQ;
                    rdreq_q <= 1'b1;
                end
                F_REQ: begin
                    if (accept) pc_q <= pc_q + ADDRBITS'(IF_PC_INC);
                    if (count_d == CNTW'(FIFODEPTH)) begin
                        state_q <= F_FULL;
                        rdreq_q <= 1'b0;
                    end
                end
                F_FULL: begin
                    if (count_d != CNTW'(FIFODEPTH)) begin
                        state_q <= F_REQ;
                        rdreq_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= F_BOOT;
                    rdreq_q <= 1'b0;
                end
            endcase
        end
    end

    instr_fetch_fifo #(
        .AW    (ADDRBITS),
        .DW    (DATABITS),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (accept),
        .push_pc_i    (pc_q),
        .push_instr_i (icache_out),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .head_pc_o    (instr_pc),
        .head_instr_o (instr_out)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. The cache is modelled as always returning
// addr ^ MAGIC for the current address; inputs change and outputs are
// checked on the falling edge.
module tb_instr_fetch;

    localparam logic [31:0] MAGIC = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] icache_addr;
    logic        icache_rdreq;
    logic [31:0] icache_out;
    logic        icache_out_valid;
    logic        icache_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign icache_out = icache_addr ^ MAGIC;

    instr_fetch dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .icache_addr      (icache_addr),
        .icache_rdreq     (icache_rdreq),
        .icache_out       (icache_out),
        .icache_out_valid (icache_out_valid),
        .icache_ready     (icache_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_out        (instr_out),
        .instr_pc         (instr_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_head;
        reset_n          = 1'b0;
        icache_out_valid = 1'b1;
        icache_ready     = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        instr_ready      = 1'b0;

        // Reset values
        #12;
        chk("rst_rdreq", {31'b0, icache_rdreq}, 32'd0);
        chk("rst_addr",  icache_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_out",   instr_out, 32'h0);
        chk("rst_pc",    instr_pc, 32'h0);

        // Release: one boot cycle without a request, then request at 0
        @(negedge clk);
        reset_n = 1'b1;
        chk("boot_rdreq", {31'b0, icache_rdreq}, 32'd0);
        cyc(1);
        chk("req_rdreq", {31'b0, icache_rdreq}, 32'd1);
        chk("req_addr",  icache_addr, 32'h0);
        cyc(1);
        chk("acc0_valid", {31'b0, instr_valid}, 32'd1);
        chk("acc0_pc",    instr_pc, 32'h0);
        chk("acc0_out",   instr_out, 32'h0 ^ MAGIC);
        chk("acc0_addr",  icache_addr, 32'h4);

        // Decode stalled: 4 accepts then F_FULL with request dropped
        cyc(3);
        chk("full_rdreq", {31'b0, icache_rdreq}, 32'd0);
        chk("full_addr",  icache_addr, 32'h10);
        chk("full_head",  instr_pc, 32'h0);
        cyc(2);
        chk("full_hold_rdreq", {31'b0, icache_rdreq}, 32'd0);
        chk("full_hold_addr",  icache_addr, 32'h10);

        // One pop resumes fetch at 0x10
        instr_ready = 1'b1;
        cyc(1);
        chk("resume_rdreq", {31'b0, icache_rdreq}, 32'd1);
        chk("resume_addr",  icache_addr, 32'h10);
        chk("resume_head",  instr_pc, 32'h4);

        // Push and pop each cycle: in-order heads, occupancy steady
        exp_head = 32'h8;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("stream_pc",    instr_pc, exp_head);
            chk("stream_out",   instr_out, exp_head ^ MAGIC);
            chk("stream_valid", {31'b0, instr_valid}, 32'd1);
            chk("stream_addr",  icache_addr, exp_head + 32'hC);
            exp_head = exp_head + 32'h4;
        end

        // Redirect to 0x2000 and buffer two entries
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        instr_ready    = 1'b0;
        cyc(1);
        redirect_valid = 1'b0;
        chk("redir1_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir1_addr",  icache_addr, 32'h2000);
        chk("redir1_rdreq", {31'b0, icache_rdreq}, 32'd1);
        cyc(2);
        chk("two_addr", icache_addr, 32'h2008);
        chk("two_head", instr_pc, 32'h2000);

        // Redirect with valid response and a pop in the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1003;
        instr_ready    = 1'b1;
        cyc(1);
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        chk("redir2_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir2_out",   instr_out, 32'h0);
        chk("redir2_pc",    instr_pc, 32'h0);
        chk("redir2_addr",  icache_addr, 32'h1000);
        cyc(1);
        chk("post_redir_pc",  instr_pc, 32'h1000);
        chk("post_redir_out", instr_out, 32'h1000 ^ MAGIC);
        chk("post_redir_addr", icache_addr, 32'h1004);

        // Cache busy for 20 cycles: address held, nothing pushed
        icache_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            chk("busy_addr", icache_addr, 32'h1004);
        end
        instr_ready = 1'b1;
        cyc(1);
        chk("busy_nopush", {31'b0, instr_valid}, 32'd0);
        instr_ready  = 1'b0;
        icache_ready = 1'b1;

        // PC wraparound at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc(1);
        redirect_valid = 1'b0;
        chk("wrap_addr0", icache_addr, 32'hFFFF_FFFC);
        cyc(1);
        chk("wrap_addr1", icache_addr, 32'h0);
        chk("wrap_head",  instr_pc, 32'hFFFF_FFFC);

        // Fill to F_FULL, then async reset pulse between clock edges
        cyc(4);
        chk("full2_rdreq", {31'b0, icache_rdreq}, 32'd0);
        chk("full2_addr",  icache_addr, 32'hC);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_rdreq", {31'b0, icache_rdreq}, 32'd0);
        chk("arst_addr",  icache_addr, 32'h0);
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_out",   instr_out, 32'h0);
        chk("arst_pc",    instr_pc, 32'h0);
        #1 reset_n = 1'b1;
        cyc(1);
        chk("restart_rdreq", {31'b0, icache_rdreq}, 32'd1);
        chk("restart_addr",  icache_addr, 32'h0);
        cyc(1);
        chk("restart_head",  instr_pc, 32'h0);
        chk("restart_valid", {31'b0, instr_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
